// File: rtl/lut_acc_pkg.sv
// Shared types and default sizing for the LUT product accumulator slice.
// Optional signed (offset-binary) accumulation is enabled by LUT_ACC_SIGNED_EN.
package lut_acc_pkg;

    localparam int PROD_W  = 11;
    localparam int A_CONST = 32;
    localparam int N_TERMS = 8;
    localparam int ACC_W   = PROD_W + $clog2(N_TERMS) + 1;
    localparam int CNT_W   = $clog2(N_TERMS) + 1;

    // Product of the midpoint operand X=16; subtracting it re-centres X on zero.
    function automatic int offset_for(input int a_const);
        return 16 * a_const;
    endfunction

    localparam int OFFSET = offset_for(A_CONST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } lut_acc_state_e;

endpackage

// File: rtl/lut_product_accumulator_if.sv
// Product input and frame-sum output handshakes of the LUT product accumulator.
// Both ports: a transfer happens on a rising clk edge where valid && ready; ready never depends on valid.
interface lut_product_accumulator_if #(
    parameter int PROD_W = lut_acc_pkg::PROD_W,
    parameter int ACC_W  = lut_acc_pkg::ACC_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;

    modport master (
        output in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/lut_acc_term_conv.sv
// Converts a multiplier product into an accumulator term: zero-extension by default,
// or (X-16)*A in two's complement when LUT_ACC_SIGNED_EN is defined.
module lut_acc_term_conv #(
    parameter int PROD_W  = lut_acc_pkg::PROD_W,
    parameter int ACC_W   = lut_acc_pkg::ACC_W,
    parameter int A_CONST = lut_acc_pkg::A_CONST
) (
    input  logic [PROD_W-1:0] in_product,
    output logic [ACC_W-1:0]  term
);
    import lut_acc_pkg::*;

`ifdef LUT_ACC_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    // ACC_W exceeds PROD_W, so the wrapped difference is already the sign-extended term.
    localparam logic [ACC_W-1:0] SUB = SIGNED_MODE ? ACC_W'(offset_for(A_CONST)) : '0;

    assign term = ACC_W'(in_product) - SUB;

endmodule

// File: rtl/lut_product_accumulator.sv
// Accumulates frames of N_TERMS multiplier products and presents each frame sum on a
// valid/ready port. Signed offset-binary mode is selected by LUT_ACC_SIGNED_EN.
module lut_product_accumulator #(
    parameter int PROD_W  = lut_acc_pkg::PROD_W,
    parameter int A_CONST = lut_acc_pkg::A_CONST,
    parameter int N_TERMS = lut_acc_pkg::N_TERMS,
    localparam int ACC_W  = PROD_W + $clog2(N_TERMS) + 1,
    localparam int CNT_W  = $clog2(N_TERMS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        clear,
    lut_product_accumulator_if.slave    bus,
    output logic [CNT_W-1:0]            term_count,
    output logic                        busy,
    output lut_acc_pkg::lut_acc_state_e state
);
    import lut_acc_pkg::*;

    lut_acc_state_e   state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] count_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] acc_sum;
    logic             last_term;

    lut_acc_term_conv #(
        .PROD_W  (PROD_W),
        .ACC_W   (ACC_W),
        .A_CONST (A_CONST)
    ) u_term_conv (
        .in_product (bus.in_product),
        .term       (term)
    );

    assign acc_sum   = acc_q + term;
    assign last_term = (count_q == CNT_W'(N_TERMS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            // Abort keeps the last delivered sum visible on out_sum.
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        count_q <= '0;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q   <= acc_sum;
                        count_q <= count_q + 1'b1;
                        if (last_term) begin
                            state_q     <= HOLD;
                            out_sum_q   <= acc_sum;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        count_q     <= '0;
                        state_q     <= start ? ACCUM : IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    count_q     <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign term_count    = count_q;
    assign busy          = (state_q != IDLE);
    assign state         = state_q;

endmodule

// File: doc/lut_product_accumulator.md
Name: lut_product_accumulator

Overview:
- Downstream consumer of the LUT-based constant multiplier. Each multiplier result is the constant A times a 5-bit operand X.
- Accepts one product per valid/ready handshake and accumulates a frame of N_TERMS products into a wide register.
- Presents the frame sum on a valid/ready output port, so the memory-based multiplier becomes a serial inner-product / FIR tap-sum stage.

Parameters:
- PROD_W, 11: width of the incoming product; covers A*X for A=32, X in 0..31.
- A_CONST, 32: multiplier constant; used only by the optional signed mode.
- N_TERMS, 8: products per frame; must be ≥2.
- ACC_W, PROD_W+$clog2(N_TERMS)+1: accumulator and out_sum width; the extra bit is the sign in signed mode.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a new frame; honoured only in IDLE, or in HOLD in the same cycle as the output handshake
- clear  in  1  synchronous abort; returns to IDLE
- in_valid  in  1  product available
- in_ready  out  1  block accepts a product this cycle
- in_product  in  PROD_W  unsigned product from the multiplier
- out_valid  out  1  frame sum valid
- out_ready  in  1  consumer accepts the sum
- out_sum  out  ACC_W  frame sum
- term_count  out  $clog2(N_TERMS)+1  products accepted in the current frame
- busy  out  1  high in ACCUM or HOLD

Behaviour:
- Reset (priority over everything):
  - state=IDLE; acc=0; term_count=0; out_sum=0; out_valid=0; in_ready=0; busy=0.
- State IDLE:
  - in_ready=0.
  - start=1 → ACCUM next cycle with acc=0 and term_count=0.
- State ACCUM:
  - in_ready=1, combinationally decoded from state only; it never depends on in_valid.
  - On in_valid&&in_ready: acc += term, term_count += 1.
  - When the accepted product is the N_TERMS-th, the next state is HOLD. out_sum is registered with the final acc (including that product) and out_valid=1 on the next cycle.
  - Latency: last input handshake to out_valid is 1 cycle.
  - in_valid low cycles (gaps) are allowed; acc and term_count hold.
- State HOLD:
  - in_ready=0; out_valid=1; out_sum stable until the handshake.
  - On out_valid&&out_ready: out_valid=0 next cycle. Next state is ACCUM (acc and count cleared) if start=1 in the same cycle, otherwise IDLE.
- start in ACCUM, or in HOLD without the handshake: ignored.
- clear (any state, below reset): next state IDLE; acc=0; term_count=0; out_valid=0; out_sum holds its last value. A product presented in the same cycle as clear is dropped. clear and start in the same cycle: clear wins.
- Arithmetic:
  - Unsigned mode: term = zero-extended in_product.
  - No overflow is possible: ACC_W ≥ PROD_W+clog2(N_TERMS).
- term_count: reads N_TERMS while in HOLD; returns to 0 on leaving HOLD.

Optional Feature:
- Macro LUT_ACC_SIGNED_EN.
- Defined: X is treated as offset-binary. term = in_product − 16*A_CONST, sign-extended to ACC_W, giving term = (X−16)*A. acc and out_sum are two's complement.
- Undefined: unsigned accumulation as above; out_sum MSB is always 0 for the default parameters.

Decomposition:
- Package lut_acc_pkg holds:
  - state enum {IDLE, ACCUM, HOLD} (2 bits)
  - default widths PROD_W, ACC_W
  - OFFSET constant 16*A_CONST
- One sub-module, lut_acc_term_conv (combinational): in_product → ACC_W term. It performs zero-extension, or offset-subtract plus sign-extension under LUT_ACC_SIGNED_EN.
- FSM, counter and accumulator stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: start, then products for X=1..8 (32,64,…,256) with in_valid held high.
  - Expected: out_valid 1 cycle after the 8th handshake; out_sum=1152; term_count=8.
  - With LUT_ACC_SIGNED_EN the same stimulus gives out_sum=−2944.
- Maximum value and gaps:
  - Stimulus: 8 products of 992 (X=31), with in_valid dropped every other cycle.
  - Expected: out_sum=7936; acc unchanged on gap cycles; 16 cycles of input phase.
- Output backpressure:
  - Stimulus: out_ready held low for 5 cycles in HOLD, with in_valid=1 throughout.
  - Expected: in_ready=0, out_sum stable, no product consumed; IDLE the cycle after out_ready rises.
- Back-to-back frames:
  - Stimulus: start=1 in the same cycle as the HOLD handshake.
  - Expected: ACCUM next cycle with acc=0; the second frame of 8×32 yields 256.
- Abort:
  - Stimulus: clear after 3 accepted products; later a fresh start with 8×64.
  - Expected: out_valid never rises for the aborted frame; the next sum is 512.
- Reset and clear conflict:
  - Stimulus: reset asserted in ACCUM together with clear and start.
  - Expected: all outputs at reset values next cycle; start ignored.
